// File: rtl/seg_disp_pkg.sv
// -----------------------------------------------------------------------------
// seg_disp_pkg
// Shared types and constants for the 7-segment display arbiter.
//   state_e        : arbiter FSM states (IDLE / SHOW / BLANK)
//   ANODE_OFF      : all digit enables inactive (active-low)
//   SEG_OFF        : all segments dark, dp off (active-low)
//   HEX_SEG_TABLE  : hex digit -> active-low {dp,g,f,e,d,c,b,a}
//   rr_pick        : round-robin search starting just above the last owner
// -----------------------------------------------------------------------------
package seg_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [7:0] SEG_OFF   = 8'hFF;

    // Index 0 is the rightmost element of the concatenation.
    localparam logic [15:0][7:0] HEX_SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Returns {found, index}. Candidates are visited last+4 down to last+1 so
    // the nearest set bit above last_owner is the one left standing.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last_owner);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            cand = last_owner + 2'(i);
            if (req[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
// Combinational hex nibble to active-low 7-segment pattern (dp always off).
//   nibble  in  4  value 0..F
//   segment out 8  {dp,g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg_hex_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] segment
);

    assign segment = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
// Shares one 4-digit multiplexed 7-segment display between four requesters.
// Round-robin ownership with a minimum dwell time when others wait, and a
// blanking gap (all anodes off) at every ownership handover.
//
// Ports
//   clock     in   1   system clock, rising edge
//   reset     in   1   asynchronous, active-high
//   req       in   4   per-source display request
//   data      in   64  per-source 16-bit value, source i on [16i+15:16i]
//   grant     out  4   one-hot display owner, 0 when none
//   anode     out  4   active-low digit enables, digit 0 on bit 0
//   segment   out  8   active-low {dp,g,f,e,d,c,b,a}
//   handover  out  1   pulses on the cycle grant takes a new non-zero owner
//
// Build option
//   SEG_ARB_ZERO_BLANK_EN : when defined, leading-zero digits are blanked
//                           (digit 0 is always shown).
// -----------------------------------------------------------------------------
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 16384,
    parameter int DWELL_CYCLES = 1000000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [63:0] data,
    output logic [3:0]  grant,
    output logic [3:0]  anode,
    output logic [7:0]  segment,
    output logic        handover
);

    localparam int PW = (SCAN_DIV     > 1) ? $clog2(SCAN_DIV)     : 1;
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_MAX = BW'(BLANK_CYCLES - 1);

    state_e        state_q,     state_d;
    logic [3:0]    grant_q,     grant_d;
    logic          handover_q,  handover_d;
    logic [3:0]    anode_q,     anode_d;
    logic [7:0]    segment_q,   segment_d;
    logic [PW-1:0] presc_q,     presc_d;
    logic [1:0]    digit_q,     digit_d;
    logic [DW-1:0] dwell_q,     dwell_d;
    logic [BW-1:0] blank_q,     blank_d;
    // Holds the current owner while in SHOW and the previous one otherwise.
    logic [1:0]    last_owner_q, last_owner_d;

    logic [2:0]    pick;
    logic [3:0]    others_req;
    logic [15:0]   owner_data;
    logic [3:0]    nibble;
    logic [7:0]    seg_dec;
    logic          digit_lit;

    // ---------------------------------------------------------------- FSM ---
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        handover_d   = 1'b0;
        last_owner_d = last_owner_q;
        dwell_d      = dwell_q;
        blank_d      = blank_q;

        // Scan prescaler runs in every state.
        presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        digit_d = (presc_q == PRESC_MAX) ? digit_q + 2'd1 : digit_q;

        pick       = rr_pick(req, last_owner_q);
        others_req = req & ~grant_q;

        case (state_q)
            ST_IDLE: begin
                if (pick[2]) begin
                    state_d      = ST_SHOW;
                    grant_d      = 4'(1) << pick[1:0];
                    last_owner_d = pick[1:0];
                    dwell_d      = '0;
                    handover_d   = 1'b1;
                end
            end
            ST_SHOW: begin
                // Release takes priority; last_owner already names this source.
                if (!req[last_owner_q] || (dwell_q == DWELL_MAX && |others_req)) begin
                    state_d = ST_BLANK;
                    grant_d = 4'b0000;
                    blank_d = '0;
                end else if (dwell_q != DWELL_MAX) begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ST_BLANK: begin
                if (blank_q == BLANK_MAX) begin
                    if (pick[2]) begin
                        state_d      = ST_SHOW;
                        grant_d      = 4'(1) << pick[1:0];
                        last_owner_d = pick[1:0];
                        dwell_d      = '0;
                        handover_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------ display ---
    // Pins are driven from next-state ownership so blanking lines up exactly
    // with grant, while digit index and data still see one register of delay.
    assign owner_data = data[{last_owner_d, 4'b0000} +: 16];
    assign nibble     = owner_data[{digit_q, 2'b00} +: 4];

    seg_hex_decode u_hex (
        .nibble  (nibble),
        .segment (seg_dec)
    );

`ifdef SEG_ARB_ZERO_BLANK_EN
    logic [1:0] top_digit;
    always_comb begin
        top_digit = 2'd0;
        for (int k = 1; k < 4; k++) begin
            if (owner_data[4*k +: 4] != 4'h0) top_digit = 2'(k);
        end
    end
    assign digit_lit = (digit_q <= top_digit);
`else
    assign digit_lit = 1'b1;
`endif

    always_comb begin
        anode_d   = ANODE_OFF;
        segment_d = SEG_OFF;
        if (state_d == ST_SHOW && digit_lit) begin
            anode_d   = ~(4'(1) << digit_q);
            segment_d = seg_dec;
        end
    end

    // -------------------------------------------------------------- flops ---
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 4'b0000;
            handover_q   <= 1'b0;
            anode_q      <= ANODE_OFF;
            segment_q    <= SEG_OFF;
            presc_q      <= '0;
            digit_q      <= 2'd0;
            dwell_q      <= '0;
            blank_q      <= '0;
            last_owner_q <= 2'd3;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            handover_q   <= handover_d;
            anode_q      <= anode_d;
            segment_q    <= segment_d;
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            dwell_q      <= dwell_d;
            blank_q      <= blank_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign grant    = grant_q;
    assign handover = handover_q;
    assign anode    = anode_q;
    assign segment  = segment_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg_display_arbiter
// Directed scenarios followed by random requests/data, all compared every
// cycle against a behavioural model of the arbitration and scan rules.
// Honours SEG_ARB_ZERO_BLANK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_seg_display_arbiter;

    localparam int SD = 4;   // scan divider
    localparam int DC = 8;   // dwell cycles
    localparam int BC = 4;   // blank cycles

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = 4'b0000;
    logic [63:0] data  = 64'h0;
    logic [3:0]  grant;
    logic [3:0]  anode;
    logic [7:0]  segment;
    logic        handover;

    seg_display_arbiter #(
        .SCAN_DIV     (SD),
        .DWELL_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .data     (data),
        .grant    (grant),
        .anode    (anode),
        .segment  (segment),
        .handover (handover)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model: mode 0 = idle, 1 = showing, 2 = blanking.
    int         m_mode, m_owner, m_dwell, m_blank, m_presc, m_digit;
    logic [3:0] e_grant, e_anode;
    logic [7:0] e_seg;
    logic       e_ho;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_mode = 0; m_owner = 3; m_dwell = 0; m_blank = 0; m_presc = 0; m_digit = 0;
        e_grant = 4'b0000; e_anode = 4'b1111; e_seg = 8'hFF; e_ho = 1'b0;
    endtask

    // Advance the model by one clock using the current req/data.
    task automatic model_step();
        int found, pd, val, nib, top;
        bit lit;
        pd    = m_digit;
        found = -1;
        for (int i = 4; i >= 1; i--)
            if (req[(m_owner + i) % 4]) found = (m_owner + i) % 4;
        e_ho = 1'b0;
        case (m_mode)
            0: if (found >= 0) begin
                   m_mode = 1; m_owner = found; m_dwell = 0; e_ho = 1'b1;
               end
            1: begin
                   if (!req[m_owner] ||
                       (m_dwell == DC - 1 && (req & ~(4'b0001 << m_owner)) != 4'b0000)) begin
                       m_mode = 2; m_blank = 0;
                   end else if (m_dwell < DC - 1) begin
                       m_dwell++;
                   end
               end
            default: begin
                   if (m_blank == BC - 1) begin
                       if (found >= 0) begin
                           m_mode = 1; m_owner = found; m_dwell = 0; e_ho = 1'b1;
                       end else begin
                           m_mode = 0;
                       end
                   end else begin
                       m_blank++;
                   end
               end
        endcase
        if (m_presc == SD - 1) begin
            m_presc = 0;
            m_digit = (m_digit + 1) % 4;
        end else begin
            m_presc++;
        end
        e_grant = (m_mode == 1) ? 4'(1 << m_owner) : 4'b0000;
        val = int'(data[16*m_owner +: 16]);
        nib = (val >> (4 * pd)) & 15;
        top = 0;
        for (int k = 1; k < 4; k++)
            if (((val >> (4 * k)) & 15) != 0) top = k;
`ifdef SEG_ARB_ZERO_BLANK_EN
        lit = (pd <= top);
`else
        lit = 1'b1;
`endif
        if (m_mode == 1 && lit) begin
            e_anode = ~4'(1 << pd);
            e_seg   = hex_tab[nib];
        end else begin
            e_anode = 4'b1111;
            e_seg   = 8'hFF;
        end
    endtask

    task automatic do_cycle();
        model_step();
        @(posedge clock);
        #1;
        check("grant",    grant,    e_grant);
        check("anode",    anode,    e_anode);
        check("segment",  segment,  e_seg);
        check("handover", handover, e_ho);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_grant"},    grant,    4'b0000);
        check({tag, "_anode"},    anode,    4'b1111);
        check({tag, "_segment"},  segment,  8'hFF);
        check({tag, "_handover"}, handover, 1'b0);
        reset_model();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    logic [3:0] seen;
    int         n;

    initial begin
        reset_model();
        repeat (2) @(posedge clock);
        #1;
        check("rst_grant",    grant,    4'b0000);
        check("rst_anode",    anode,    4'b1111);
        check("rst_segment",  segment,  8'hFF);
        check("rst_handover", handover, 1'b0);
        reset = 1'b0;

        // Single requester, value 1234 scanned across all digits.
        req  = 4'b0001;
        data = 64'h0000_0000_0000_1234;
        do_cycle();
        check("t1_grant",    grant,    4'b0001);
        check("t1_handover", handover, 1'b1);
        seen = 4'b0000;
        repeat (4 * SD) begin
            do_cycle();
            case (anode)
                4'b1110: begin check("t1_dig0", segment, 8'h99); seen[0] = 1'b1; end
                4'b1101: begin check("t1_dig1", segment, 8'hB0); seen[1] = 1'b1; end
                4'b1011: begin check("t1_dig2", segment, 8'hA4); seen[2] = 1'b1; end
                4'b0111: begin check("t1_dig3", segment, 8'hF9); seen[3] = 1'b1; end
                default: ;
            endcase
        end
        check("t1_all_digits", seen, 4'b1111);

        // Two requesters: dwell expiry then blank gap then handover to source 1.
        apply_reset("t2_rst");
        req  = 4'b0011;
        data = 64'h0000_0000_5678_1234;
        do_cycle();
        n = 0;
        while (grant == 4'b0001 && n < 20) begin n++; do_cycle(); end
        check("t2_dwell_len", n, 8);
        n = 0;
        while (grant == 4'b0000 && anode == 4'b1111 && n < 20) begin n++; do_cycle(); end
        check("t2_blank_len", n, 4);
        check("t2_grant",    grant,    4'b0010);
        check("t2_handover", handover, 1'b1);

        // Owner 3 releases; search wraps to source 0.
        apply_reset("t3_rst");
        req  = 4'b1000;
        data = 64'h4321_0000_0000_00AB;
        do_cycle();
        check("t3_grant3", grant, 4'b1000);
        repeat (3) do_cycle();
        req = 4'b0101;
        do_cycle();
        check("t3_blank", grant, 4'b0000);
        repeat (3) do_cycle();
        do_cycle();
        check("t3_wrap_grant", grant,    4'b0001);
        check("t3_wrap_ho",    handover, 1'b1);

        // Reset during BLANK, then during SHOW.
        req = 4'b0000;
        do_cycle();
        do_cycle();
        apply_reset("t4_blank_rst");
        req = 4'b1000;
        do_cycle();
        check("t4_grant", grant, 4'b1000);
        repeat (5) do_cycle();
        apply_reset("t4_show_rst");

        // Leading-zero handling.
        req  = 4'b0001;
        data = 64'h0000_0000_0000_0007;
        do_cycle();
        repeat (4 * SD) begin
            do_cycle();
`ifdef SEG_ARB_ZERO_BLANK_EN
            if (anode != 4'b1111) begin
                check("t5_zb_anode", anode,   4'b1110);
                check("t5_zb_seg",   segment, 8'hF8);
            end
`else
            if (anode != 4'b1111)
                check("t5_seg", segment, (anode == 4'b1110) ? 8'hF8 : 8'hC0);
`endif
        end
        data = 64'h0;
        repeat (4 * SD) begin
            do_cycle();
`ifdef SEG_ARB_ZERO_BLANK_EN
            if (anode != 4'b1111) check("t5_zb0_anode", anode, 4'b1110);
`endif
            if (anode != 4'b1111) check("t5_zero_seg", segment, 8'hC0);
        end

        // Random traffic against the model.
        apply_reset("t6_rst");
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 11) == 0) req = 4'($urandom);
            if ($urandom_range(0, 15) == 0) data = {$urandom, $urandom};
            do_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
